call_request_queue: RTL

CALL_REQUEST_QUEUE -- requirements
Module: call_request_queue

---
 rtl/call_request_queue_pkg.sv | 31 +++
 rtl/call_request_queue_rr_find.sv | 28 ++
 rtl/call_request_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/call_request_queue_pkg.sv
// Shared definitions for the hall-call request queue: widths, car-status field
// positions, FSM encoding and a helper that decodes a car status word.
package call_request_queue_pkg;

    localparam int unsigned FLOOR_W    = 4;
    localparam int unsigned NUM_FLOORS = 16;
    localparam int unsigned STATUS_W   = 6;

    // Car status word layout
    localparam int unsigned FLOOR_MSB  = 5;
    localparam int unsigned FLOOR_LSB  = 2;
    localparam int unsigned DIR_BIT    = 1;
    localparam int unsigned MOVE_BIT   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // One-hot mask of the floor a stopped car is standing at; empty while the car moves.
    function automatic logic [NUM_FLOORS-1:0] servedMask(input logic [STATUS_W-1:0] status);
        logic [NUM_FLOORS-1:0] mask;
        mask = '0;
        if (!status[MOVE_BIT]) begin
            mask[status[FLOOR_MSB:FLOOR_LSB]] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/call_request_queue_rr_find.sv
// Combinational round-robin finder: first set bit of reqVec at or after ptr,
// wrapping from the top floor back to floor 0.
module rr_find
    import call_request_queue_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] reqVec,
    input  logic [FLOOR_W-1:0]    ptr,
    output logic [FLOOR_W-1:0]    idx,
    output logic                  found
);

    logic [FLOOR_W-1:0] cand;

    // Scan floors in rotated order starting at ptr; 4-bit addition gives the wrap.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            cand = ptr + FLOOR_W'(i);
            if (!found && reqVec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_request_queue.sv
// Hall-call request queue: latches button presses into a pending bitmap,
// offers pending floors one at a time (round-robin) to the control unit and
// retires a floor once a stopped car stands at it.
module call_request_queue
    import call_request_queue_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [STATUS_W-1:0]   stateFloorA,
    input  logic [STATUS_W-1:0]   stateFloorB,
    input  logic [STATUS_W-1:0]   stateFloorC,
    output logic [FLOOR_W-1:0]    obj,
    output logic                  objValid,
    output logic [NUM_FLOORS-1:0] pending
);

    state_t                state;
    logic [NUM_FLOORS-1:0] btnQ;
    logic [NUM_FLOORS-1:0] dispatched;
    logic [FLOOR_W-1:0]    ptr;
    logic [FLOOR_W-1:0]    gapCnt;

    logic [NUM_FLOORS-1:0] served;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] eligible;
    logic [NUM_FLOORS-1:0] dispSet;
    logic [FLOOR_W-1:0]    selIdx;
    logic                  selFound;

    rr_find uRrFind (
        .reqVec (eligible),
        .ptr    (ptr),
        .idx    (selIdx),
        .found  (selFound)
    );

    // Served floors, new presses, offerable floors and the floor being dispatched now.
    always_comb begin
        served   = servedMask(stateFloorA) | servedMask(stateFloorB) | servedMask(stateFloorC);
        press    = btn & ~btnQ;
        eligible = pending & ~dispatched;
        dispSet  = '0;
        if (state == IDLE && selFound) begin
            dispSet = NUM_FLOORS'(1) << selIdx;
        end
    end

    // Bitmaps, edge detector and dispatch FSM; a serve clears a floor even if set this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            btnQ       <= btn;
            pending    <= '0;
            dispatched <= '0;
            obj        <= '0;
            objValid   <= 1'b0;
            ptr        <= '0;
            gapCnt     <= '0;
            state      <= IDLE;
        end else begin
            btnQ       <= btn;
            pending    <= (pending | (press & ~served)) & ~served;
            dispatched <= (dispatched | dispSet) & ~served;
            objValid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (selFound) begin
                        obj      <= selIdx;
                        objValid <= 1'b1;
                        ptr      <= selIdx + FLOOR_W'(1);
                        gapCnt   <= FLOOR_W'(GAP_CYCLES - 1);
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= GAP;
                end
                GAP: begin
                    if (gapCnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt - FLOOR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
